// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 has priority, bounded by MAX_BURST so port 1 cannot starve.
// Latency: grant in the same cycle as the request; read data and RValid are registered, 1 cycle after the grant.
// Backpressure: a requester holds Req/WE/A/WD until its Gnt is seen high. `DMEM_ARB_STATS_EN adds grant and wait counters.
module dmem_arbiter #(
    parameter int SIZE      = 48,
    parameter int MAX_BURST = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Req0,
    input  logic            Req1,
    input  logic            WE0,
    input  logic            WE1,
    input  logic [SIZE-1:0] A0,
    input  logic [SIZE-1:0] A1,
    input  logic [SIZE-1:0] WD0,
    input  logic [SIZE-1:0] WD1,
    output logic            Gnt0,
    output logic            Gnt1,
    output logic            RValid0,
    output logic            RValid1,
    output logic [SIZE-1:0] RD0,
    output logic [SIZE-1:0] RD1,
    output logic            MemWE,
    output logic [SIZE-1:0] MemA,
    output logic [SIZE-1:0] MemWD,
    input  logic [SIZE-1:0] MemRD
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]     StatGnt0,
    output logic [31:0]     StatGnt1,
    output logic [31:0]     StatWait
`endif
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t     state;
    logic [3:0] bcnt;
    logic       win0;
    logic       win1;

    // Port 0 wins unless port 1 is waiting and the burst budget is spent.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (!Reset) begin
            win0 = Req0 && (!Req1 || (bcnt < MAX_B));
            win1 = Req1 && !win0;
        end
    end

    assign Gnt0  = win0;
    assign Gnt1  = win1;
    assign MemA  = win1 ? A1  : A0;
    assign MemWD = win1 ? WD1 : WD0;
    assign MemWE = (win0 && WE0) || (win1 && WE1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            bcnt    <= 4'd0;
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
            RD0     <= '0;
            RD1     <= '0;
        end else begin
            if (win0)
                state <= OWN0;
            else if (win1)
                state <= OWN1;
            else
                state <= IDLE;

            // Only a contested port-0 win extends the burst; anything else restarts it.
            bcnt    <= (win0 && Req1) ? bcnt + 4'd1 : 4'd0;

            RValid0 <= win0 && !WE0;
            RValid1 <= win1 && !WE1;
            if (win0 && !WE0)
                RD0 <= MemRD;
            if (win1 && !WE1)
                RD1 <= MemRD;
        end
    end

    // Owner state is for observation only; keep it consistent with the grants.
    a_own0: assert property (@(posedge CLK) disable iff (Reset) Gnt0 |=> (state == OWN0));
    a_own1: assert property (@(posedge CLK) disable iff (Reset) Gnt1 |=> (state == OWN1));

`ifdef DMEM_ARB_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + 33'(inc);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [1:0] wait_inc;
    assign wait_inc = {1'b0, Req0 && !win0} + {1'b0, Req1 && !win1};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            StatGnt0 <= 32'd0;
            StatGnt1 <= 32'd0;
            StatWait <= 32'd0;
        end else begin
            StatGnt0 <= sat_add(StatGnt0, {1'b0, win0});
            StatGnt1 <= sat_add(StatGnt1, {1'b0, win1});
            StatWait <= sat_add(StatWait, wait_inc);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word memory model on the memory side.
module tb_dmem_arbiter;

    localparam int SIZE = 48;

    logic            CLK = 1'b0;
    logic            Reset;
    logic            Req0, Req1, WE0, WE1;
    logic [SIZE-1:0] A0, A1, WD0, WD1;
    logic            Gnt0, Gnt1, RValid0, RValid1;
    logic [SIZE-1:0] RD0, RD1;
    logic            MemWE;
    logic [SIZE-1:0] MemA, MemWD, MemRD;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]     StatGnt0, StatGnt1, StatWait;
`endif

    logic [SIZE-1:0] mem [0:15];
    int checks = 0;
    int errors = 0;
    logic [9:0] pat;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.SIZE(SIZE), .MAX_BURST(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .WE0(WE0), .WE1(WE1),
        .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
        .RD0(RD0), .RD1(RD1),
        .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD)
`ifdef DMEM_ARB_STATS_EN
        , .StatGnt0(StatGnt0), .StatGnt1(StatGnt1), .StatWait(StatWait)
`endif
    );

    assign MemRD = mem[MemA[3:0]];

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (MemWE) begin
            mem[MemA[3:0]] <= MemWD;
        end
    end

    task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Req0 = 1'b1; WE0 = 1'b1; A0 = 48'd3; WD0 = 48'd77;
        Req1 = 1'b0; WE1 = 1'b0; A1 = 48'd0; WD1 = 48'd0;
        #1;
        check("rst_memwe", {47'd0, MemWE}, 48'd0);
        check("rst_gnt0", {47'd0, Gnt0}, 48'd0);
        check("rst_rvalid0", {47'd0, RValid0}, 48'd0);
        check("rst_rd0", RD0, 48'd0);
        check("rst_mema", MemA, 48'd3);
        tick();
        tick();
        check("rst_hold_memwe", {47'd0, MemWE}, 48'd0);

        // Release reset with the write still requested: it goes through at once.
        Reset = 1'b0;
        #1;
        check("rel_gnt0", {47'd0, Gnt0}, 48'd1);
        check("rel_memwe", {47'd0, MemWE}, 48'd1);
        tick();
        check("rel_mem3", mem[3], 48'd77);

        // Single port write then read of addr 5.
        A0 = 48'd5; WD0 = 48'h0000_0000_00AB; WE0 = 1'b1;
        #1;
        check("sp_wr_gnt0", {47'd0, Gnt0}, 48'd1);
        check("sp_wr_memwe", {47'd0, MemWE}, 48'd1);
        tick();
        WE0 = 1'b0;
        #1;
        check("sp_rd_gnt0", {47'd0, Gnt0}, 48'd1);
        check("sp_rd_memwe", {47'd0, MemWE}, 48'd0);
        check("sp_wr_no_rvalid", {47'd0, RValid0}, 48'd0);
        tick();
        Req0 = 1'b0;
        #1;
        check("sp_rvalid0", {47'd0, RValid0}, 48'd1);
        check("sp_rd0", RD0, 48'hAB);
        tick();
        A0 = 48'd2; WD0 = 48'd55;
        #1;
        check("sp_rvalid0_pulse", {47'd0, RValid0}, 48'd0);
        check("sp_rd0_hold", RD0, 48'hAB);
        check("idle_gnt0", {47'd0, Gnt0}, 48'd0);
        check("idle_mema", MemA, 48'd2);
        check("idle_memwd", MemWD, 48'd55);
        tick();

        // Contention: both ports read continuously.
        pat = 10'b10_0001_0000;
        Req0 = 1'b1; WE0 = 1'b0; A0 = 48'd5;
        Req1 = 1'b1; WE1 = 1'b0; A1 = 48'd3;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("cont_gnt0_%0d", i), {47'd0, Gnt0}, {47'd0, ~pat[i]});
            check($sformatf("cont_gnt1_%0d", i), {47'd0, Gnt1}, {47'd0, pat[i]});
            if (i > 0) begin
                check($sformatf("cont_rv1_%0d", i), {47'd0, RValid1}, {47'd0, pat[i-1]});
                check($sformatf("cont_rv0_%0d", i), {47'd0, RValid0}, {47'd0, ~pat[i-1]});
            end
            tick();
        end
        check("cont_rv1_last", {47'd0, RValid1}, 48'd1);
        check("cont_rd1", RD1, 48'd77);
        check("cont_rd0", RD0, 48'hAB);
`ifdef DMEM_ARB_STATS_EN
        check("stat_gnt0_a", {16'd0, StatGnt0}, 48'd11);
        check("stat_gnt1_a", {16'd0, StatGnt1}, 48'd2);
        check("stat_wait_a", {16'd0, StatWait}, 48'd10);
`endif

        // Same-address conflict: port 0 write beats port 1 read of addr 9.
        Req0 = 1'b1; WE0 = 1'b1; A0 = 48'd9; WD0 = 48'h123;
        Req1 = 1'b1; WE1 = 1'b0; A1 = 48'd9;
        #1;
        check("conf_gnt0", {47'd0, Gnt0}, 48'd1);
        check("conf_gnt1", {47'd0, Gnt1}, 48'd0);
        check("conf_memwe", {47'd0, MemWE}, 48'd1);
        tick();
        Req0 = 1'b0;
        #1;
        check("conf_retry_gnt1", {47'd0, Gnt1}, 48'd1);
        check("conf_retry_memwe", {47'd0, MemWE}, 48'd0);
        check("conf_retry_mema", MemA, 48'd9);
        tick();
        Req1 = 1'b0;
        #1;
        check("conf_rvalid1", {47'd0, RValid1}, 48'd1);
        check("conf_rd1", RD1, 48'h123);
        tick();

        // Cancel: port 1 write raised during a port-0 burst and dropped before grant.
        Req0 = 1'b1; WE0 = 1'b0; A0 = 48'd5;
        Req1 = 1'b1; WE1 = 1'b1; A1 = 48'd7; WD1 = 48'hDEAD;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("can_gnt0_%0d", i), {47'd0, Gnt0}, 48'd1);
            check($sformatf("can_gnt1_%0d", i), {47'd0, Gnt1}, 48'd0);
            check($sformatf("can_mema_%0d", i), MemA, 48'd5);
            check($sformatf("can_memwe_%0d", i), {47'd0, MemWE}, 48'd0);
            tick();
        end
        Req1 = 1'b0;
        tick();
        tick();
        check("can_mem7", mem[7], 48'd0);
        check("can_rvalid1", {47'd0, RValid1}, 48'd0);
        // Burst count must have restarted: port 1 now waits a full 4 grants.
        Req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("can2_gnt1_%0d", i), {47'd0, Gnt1}, (i == 4) ? 48'd1 : 48'd0);
            if (i == 4) begin
                check("can2_memwe", {47'd0, MemWE}, 48'd1);
                check("can2_mema", MemA, 48'd7);
            end
            tick();
        end
        Req0 = 1'b0; Req1 = 1'b0;
        check("can2_mem7", mem[7], 48'hDEAD);
`ifdef DMEM_ARB_STATS_EN
        check("stat_gnt0_b", {16'd0, StatGnt0}, 48'd20);
        check("stat_gnt1_b", {16'd0, StatGnt1}, 48'd4);
        check("stat_wait_b", {16'd0, StatWait}, 48'd17);
`endif
        tick();

        // Reset mid-operation clears a pending RValid and blocks writes.
        Req0 = 1'b1; WE0 = 1'b0; A0 = 48'd5;
        #1;
        check("mid_gnt0", {47'd0, Gnt0}, 48'd1);
        tick();
        check("mid_rvalid0", {47'd0, RValid0}, 48'd1);
        Reset = 1'b1; WE0 = 1'b1;
        #1;
        check("mid_rst_rvalid0", {47'd0, RValid0}, 48'd0);
        check("mid_rst_rd0", RD0, 48'd0);
        check("mid_rst_memwe", {47'd0, MemWE}, 48'd0);
        check("mid_rst_gnt0", {47'd0, Gnt0}, 48'd0);
`ifdef DMEM_ARB_STATS_EN
        check("mid_rst_stat", {16'd0, StatGnt0}, 48'd0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 48-bit data memory between the pipelined CPU memory stage (port 0) and an auxiliary master such as a loader or debug port (port 1). It performs at most one access per cycle. Port 0 has priority, bounded by a burst limit so that port 1 cannot starve. The block sits between the CPU (`MemWriteM`/`ALUOutM`/`WriteDataM`/`ReadDataM`) and `dmem`. It drives the memory's `WE`/`A`/`WD` and samples `RD`.

## Interface
Parameters:
- `SIZE`, 48: data and address width.
- `MAX_BURST`, 4: maximum consecutive port-0 grants while port 1 is waiting; range 1–15.

Ports:
- `CLK` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Req0`, `Req1` in 1: access request per port.
- `WE0`, `WE1` in 1: 1 = write, 0 = read.
- `A0`, `A1` in SIZE: word address.
- `WD0`, `WD1` in SIZE: write data.
- `Gnt0`, `Gnt1` out 1: access performed this cycle (combinational).
- `RValid0`, `RValid1` out 1: read data valid (registered).
- `RD0`, `RD1` out SIZE: read data (registered).
- `MemWE` out 1: to `dmem.WE`.
- `MemA` out SIZE: to `dmem.A`.
- `MemWD` out SIZE: to `dmem.WD`.
- `MemRD` in SIZE: from `dmem.RD`; combinational read.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0: port 0 won the last cycle.
  - OWN1: port 1 won the last cycle.
- Burst counter `bcnt` (4 bits) counts consecutive port-0 grants while `Req1` is high.
- Winner decision, combinational, per cycle:
  - Neither request: no grant. Next state IDLE, `bcnt` = 0.
  - Only Reqi: port i wins.
  - Both, `bcnt` < MAX_BURST: port 0 wins, `bcnt` += 1.
  - Both, `bcnt` == MAX_BURST: port 1 wins, `bcnt` = 0.
  - Port 1 win (any case): `bcnt` = 0.
  - Port 0 win with `Req1` low: `bcnt` = 0.
- Next state = OWN0/OWN1 per winner. The state is used for stats and debug only; the decision depends only on requests and `bcnt`.
- Output mux:
  - `MemA` and `MemWD` follow the winner.
  - `MemA` and `MemWD` hold port 0 values when there is no winner.
  - `MemWE` = winner's WE AND winner exists.
  - `Gnti` = 1 only for the winner.
- Requester rule: hold Req/WE/A/WD stable until `Gnti` is seen high. Dropping Req before grant cancels the request without side effects.
- Read return:
  - On a granted read, `RDi` <= `MemRD` and `RValidi` <= 1 at the next rising edge.
  - `RValidi` is a one-cycle pulse.
  - `RDi` holds its value until the next granted read on that port.
- Writes produce no RValid.
- Back-to-back grants to the same port are allowed every cycle. Throughput is 1 access/cycle total.

## Timing
- Reset values (asynchronous, while `Reset` = 1):
  - State IDLE, `bcnt` 0.
  - `RValid0`/`RValid1` = 0, `RD0`/`RD1` = 0.
  - `Gnt0`/`Gnt1` = 0 and `MemWE` = 0 (forced combinationally).
  - `MemA` = `A0`, `MemWD` = `WD0`.
- Grant latency: 0 cycles, i.e. the same cycle as the request when uncontested.
- Read data latency: 1 cycle after the grant.
- Worst-case port-1 wait under continuous port-0 traffic: MAX_BURST cycles.
- Simultaneous events:
  - Read and write to the same address by different ports in one cycle: only the winner executes; the loser retries next cycle and sees the written data.
- Reset mid-operation: any in-flight grant is dropped and no write occurs while `Reset` is high. A pending `RValid` is cleared.
- `bcnt` never exceeds MAX_BURST; no wrap.

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds three 32-bit outputs, all saturating at 32'hFFFFFFFF and reset to 0.
  - `StatGnt0`: counts port-0 grants.
  - `StatGnt1`: counts port-1 grants.
  - `StatWait`: counts cycles with a request pending but not granted, per port, summed.
- Not defined: these ports and the counters are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Reset: hold `Reset` with `Req0`=1, `WE0`=1 -> `MemWE`=0, `Gnt0`=0, `RValid0`=0. Release -> write proceeds in the first clock cycle.
- Single port: port 0 writes 48'h0000_0000_00AB to addr 5, then reads addr 5 -> `Gnt0`=1 both cycles; `RValid0`=1 with `RD0`=48'hAB one cycle after the read grant.
- Contention: `Req0` and `Req1` held high, MAX_BURST=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1…; `Gnt1` never waits more than 4 cycles.
- Same-address conflict: port 0 writes 48'h123 to addr 9 while port 1 reads addr 9 -> write first; port-1 read granted next cycle, `RD1`=48'h123.
- Cancel: `Req1` raised during a port-0 burst, then dropped before grant -> `Gnt1` never asserted, no memory access from port 1, `bcnt` returns to 0.
- Stats build: 10 cycles of dual requests -> `StatGnt0`=8, `StatGnt1`=2, `StatWait`=10.
